ram_ch_arb: RTL and testbench

- Parametrised NUM_CH-way channel arbiter with a registered data mux for the flash-channel RAM read-out path.
- Replaces the fixed 16:1 combinational channel select with three behaviours:
  - round-robin or forced-channel arbitration;
  - burst-length-capped grants, so one channel cannot starve the others;
  - a valid/ready registered output stage tagged with the source channel number.
- Sits between the per-channel RAM buffers and the host-side DMA engine.

---
 rtl/ram_ch_arb.sv | 167 ++++++++++++++++
 tb/tb_ram_ch_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ch_arb.sv
// NUM_CH-way channel arbiter for the flash-channel RAM read-out path: round-robin or
// forced grants, burst-capped, feeding a registered valid/ready beat tagged with its channel.
module ram_ch_arb #(
  parameter int unsigned  NUM_CH    = 16,
  parameter int unsigned  DATA_W    = 1,
  parameter int unsigned  MAX_BURST = 16,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_last,
  output logic [NUM_CH-1:0]        ch_ack,
  input  logic                     force_en,
  input  logic [CH_W-1:0]          force_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch_num,
  output logic                     out_last,
  output logic                     busy
);
  localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic              pick_vld;
  logic [CH_W-1:0]   pick_ch;
  logic              req_g, last_g;
  logic [DATA_W-1:0] data_g;
  logic              can_load, ack, burst_end;
  logic [CH_W-1:0]   rr_next;

  // Channel pick for the IDLE cycle
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    if (force_en) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (force_ch == CH_W'(i) && ch_req[i]) begin
          pick_vld = 1'b1;
          pick_ch  = CH_W'(i);
        end
      end
    end else begin
      // Lowest requester at/after rr_ptr wins; otherwise the lowest one below it (wrap).
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (ch_req[i] && CH_W'(i) < rr_ptr_q) begin
          pick_vld = 1'b1;
          pick_ch  = CH_W'(i);
        end
      end
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (ch_req[i] && CH_W'(i) >= rr_ptr_q) begin
          pick_vld = 1'b1;
          pick_ch  = CH_W'(i);
        end
      end
    end
  end

  // Granted channel's request, last flag and beat
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (gnt_q == CH_W'(i)) begin
        req_g  = ch_req[i];
        last_g = ch_last[i];
        data_g = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign ack       = (state_q == XFER) && req_g && can_load;
  assign burst_end = last_g || (beat_cnt_q == CNT_LAST);
  assign rr_next   = (gnt_q == CH_MAX) ? '0 : gnt_q + CH_W'(1);

  always_comb begin
    ch_ack = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ack && gnt_q == CH_W'(i)) ch_ack[i] = 1'b1;
    end
  end

  // Next-state and output-stage logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d      = pick_ch;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (ack) begin
          out_valid_d = 1'b1;
          out_data_d  = data_g;
          out_ch_d    = gnt_q;
          out_last_d  = burst_end;
          beat_cnt_d  = beat_cnt_q + CNT_W'(1);
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = rr_next;
          end
        end else if (can_load) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch_num = out_ch_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ram_ch_arb.sv
// Directed bench for ram_ch_arb: a table of per-cycle round-robin vectors plus
// hand sequences for burst cap, abandon, backpressure, forced mode and reset.
module tb_ram_ch_arb;
  localparam int unsigned NCH = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned MB  = 4;
  localparam int unsigned BCH = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NCH-1:0]  ch_req, ch_last, ch_ack;
  logic [NCH*DW-1:0] ch_data;
  logic            force_en = 1'b0;
  logic [3:0]      force_ch = 4'd0;
  logic            out_valid, out_last, busy;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_ch_num;

  logic [BCH-1:0]  b_req = '0;
  logic [BCH-1:0]  b_ack;
  logic            b_force_en = 1'b0;
  logic [2:0]      b_force_ch = 3'd0;
  logic            b_valid, b_data, b_last, b_busy;
  logic [2:0]      b_ch;

  // Source model: table mode drives req/last directly, otherwise each channel
  // requests until it has been acked up to its target beat count.
  logic            use_tbl = 1'b1;
  logic [NCH-1:0]  tr_req = '0;
  logic [NCH-1:0]  tr_last = '0;
  int              src_cnt [NCH];
  int              tgt [NCH];

  logic [12:0]     beats [64];
  int              beat_n = 0;
  logic [12:0]     eb [16];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] last;
    logic        rdy;
    logic        busy;
    logic        vld;
    logic [3:0]  ch;
    logic [7:0]  data;
    logic        olast;
    logic [15:0] ack;
  } vec_t;
  vec_t tbl [9];

  ram_ch_arb #(.NUM_CH(NCH), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data), .ch_last(ch_last),
    .ch_ack(ch_ack), .force_en(force_en), .force_ch(force_ch), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch_num(out_ch_num),
    .out_last(out_last), .busy(busy)
  );

  ram_ch_arb #(.NUM_CH(BCH), .DATA_W(1), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst), .ch_req(b_req), .ch_data({BCH{1'b0}}), .ch_last({BCH{1'b1}}),
    .ch_ack(b_ack), .force_en(b_force_en), .force_ch(b_force_ch), .out_valid(b_valid),
    .out_ready(1'b1), .out_data(b_data), .out_ch_num(b_ch), .out_last(b_last),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      ch_req[i]           = use_tbl ? tr_req[i] : (src_cnt[i] < tgt[i]);
      ch_last[i]          = use_tbl ? tr_last[i] : 1'b0;
      ch_data[i*DW +: DW] = {4'(i), 4'(src_cnt[i])};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_ack[i]) src_cnt[i] <= src_cnt[i] + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && beat_n < 64) begin
      beats[beat_n] <= {out_ch_num, out_data, out_last};
      beat_n        <= beat_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic give(input int ch, input int n);
    tgt[ch] = src_cnt[ch] + n;
  endtask

  task automatic clear_tgt();
    for (int i = 0; i < int'(NCH); i++) tgt[i] = src_cnt[i];
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < int'(NCH); i++) if (src_cnt[i] < tgt[i]) p = 1'b1;
    if (use_tbl && tr_req != '0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (n < 200 && (pending() || busy || out_valid)) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 200), 32'd0);
  endtask

  task automatic chk_beats(input string name, input int base, input int n);
    chk({name, "_count"}, 32'(beat_n - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < 64) chk($sformatf("%s_beat%0d", name, k), 32'(beats[base+k]), 32'(eb[k]));
    end
  endtask

  initial begin
    int base;
    //             req       last      rdy busy vld ch     data   olast ack
    tbl[0] = '{16'h8005, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000};
    tbl[1] = '{16'h8005, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0001};
    tbl[2] = '{16'h8005, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'h0, 8'h00, 1'b1, 16'h0000};
    tbl[3] = '{16'h8005, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 16'h0004};
    tbl[4] = '{16'h8005, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'h2, 8'h20, 1'b1, 16'h0000};
    tbl[5] = '{16'h8005, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h2, 8'h20, 1'b1, 16'h8000};
    tbl[6] = '{16'h8005, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'hF, 8'hF0, 1'b1, 16'h0000};
    tbl[7] = '{16'h8005, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'hF, 8'hF0, 1'b1, 16'h0001};
    tbl[8] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'h0, 8'h01, 1'b1, 16'h0000};

    #1 rst = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch_num), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ack", 32'(ch_ack), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round robin 0 -> 2 -> 15 -> 0, one beat per grant
    for (int k = 0; k < 9; k++) begin
      tr_req    = tbl[k].req;
      tr_last   = tbl[k].last;
      out_ready = tbl[k].rdy;
      #1;
      chk($sformatf("rr%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
      chk($sformatf("rr%0d_valid", k), 32'(out_valid), 32'(tbl[k].vld));
      chk($sformatf("rr%0d_ch", k), 32'(out_ch_num), 32'(tbl[k].ch));
      chk($sformatf("rr%0d_data", k), 32'(out_data), 32'(tbl[k].data));
      chk($sformatf("rr%0d_last", k), 32'(out_last), 32'(tbl[k].olast));
      chk($sformatf("rr%0d_ack", k), 32'(ch_ack), 32'(tbl[k].ack));
      step();
    end

    use_tbl = 1'b0;
    clear_tgt();
    drain("idle0");

    // Burst cap on ch3, then ch5 (abandons after 2), then ch3 resumes and abandons
    base = beat_n;
    give(3, 6);
    give(5, 2);
    drain("cap");
    eb[0] = {4'h3, 8'h30, 1'b0};
    eb[1] = {4'h3, 8'h31, 1'b0};
    eb[2] = {4'h3, 8'h32, 1'b0};
    eb[3] = {4'h3, 8'h33, 1'b1};
    eb[4] = {4'h5, 8'h50, 1'b0};
    eb[5] = {4'h5, 8'h51, 1'b0};
    eb[6] = {4'h3, 8'h34, 1'b0};
    eb[7] = {4'h3, 8'h35, 1'b0};
    chk_beats("cap", base, 8);

    // Backpressure: stall 5 cycles after the second beat of ch6
    base = beat_n;
    give(6, 6);
    step();
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_ack", k), 32'(ch_ack), 32'd0);
      chk($sformatf("bp%0d_data", k), 32'(out_data), 32'h61);
      chk($sformatf("bp%0d_ch", k), 32'(out_ch_num), 32'd6);
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_busy", k), 32'(busy), 32'd1);
      step();
    end
    out_ready = 1'b1;
    drain("bp");
    eb[0] = {4'h6, 8'h60, 1'b0};
    eb[1] = {4'h6, 8'h61, 1'b0};
    eb[2] = {4'h6, 8'h62, 1'b0};
    eb[3] = {4'h6, 8'h63, 1'b1};
    eb[4] = {4'h6, 8'h64, 1'b0};
    eb[5] = {4'h6, 8'h65, 1'b0};
    chk_beats("bp", base, 6);

    // Forced mode: all channels request, only ch9 may be granted
    base     = beat_n;
    use_tbl  = 1'b1;
    tr_req   = 16'hFFFF;
    tr_last  = 16'hFFFF;
    force_en = 1'b1;
    force_ch = 4'd9;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("frc%0d_ack", k), 32'(ch_ack & ~16'h0200), 32'd0);
    end
    tr_req   = '0;
    force_en = 1'b0;
    drain("frc");
    for (int k = 0; k < 5; k++) eb[k] = {4'h9, 8'h90 + 8'(k), 1'b1};
    chk_beats("frc", base, 5);

    // Forced channel not requesting: no grant
    tr_req   = 16'hFDFF;
    force_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("frcnr%0d_busy", k), 32'(busy), 32'd0);
      chk($sformatf("frcnr%0d_ack", k), 32'(ch_ack), 32'd0);
    end
    tr_req   = '0;
    force_en = 1'b0;
    step();

    // Out-of-range force channel on a 6-channel instance
    b_req      = 6'h3F;
    b_force_en = 1'b1;
    b_force_ch = 3'd7;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("oor%0d_busy", k), 32'(b_busy), 32'd0);
      chk($sformatf("oor%0d_ack", k), 32'(b_ack), 32'd0);
    end
    b_force_ch = 3'd5;
    step();
    chk("b_busy", 32'(b_busy), 32'd1);
    chk("b_ack", 32'(b_ack), 32'h20);
    step();
    chk("b_valid", 32'(b_valid), 32'd1);
    chk("b_ch", 32'(b_ch), 32'd5);
    chk("b_last", 32'(b_last), 32'd1);
    chk("b_data", 32'(b_data), 32'd0);
    b_req      = '0;
    b_force_en = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a ch2 burst
    use_tbl = 1'b0;
    clear_tgt();
    give(2, 10);
    step();
    step();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ch_ack), 32'd0);
    clear_tgt();
    @(posedge clk);
    #1 rst = 1'b0;
    give(0, 1);
    #1;
    chk("post_rst_idle_ack", 32'(ch_ack), 32'd0);
    step();
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_ack", 32'(ch_ack), 32'h0001);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
